// File: rtl/composite_video_encoder_if.sv
// -----------------------------------------------------------------------------
// composite_video_encoder_if
// Sample-stream bundle between a video timing/colour source and the composite
// encoder.
//   palMode          : 0 = NTSC (c1=I, c2=Q), 1 = PAL (c1=U, c2=V)
//   lineStart        : one-cycle pulse at the start of each line
//   subcarrierPhase  : subcarrier phase index, PHASE_BITS wide
//   sync/burst/blank : timing flags
//   y, c1, c2        : signed luma and chroma, YUV_BITS wide
//   vSwitch          : PAL V-switch state returned by the encoder
//   dacSample        : composite DAC code returned by the encoder
// master = sample source, slave = encoder.
// -----------------------------------------------------------------------------
interface composite_video_if #(
    parameter int unsigned PHASE_BITS = 4,
    parameter int unsigned DAC_BITS   = 5,
    parameter int unsigned YUV_BITS   = 9
);
    logic                        palMode;
    logic                        lineStart;
    logic [PHASE_BITS-1:0]       subcarrierPhase;
    logic                        sync;
    logic                        burst;
    logic                        blank;
    logic signed [YUV_BITS-1:0]  y;
    logic signed [YUV_BITS-1:0]  c1;
    logic signed [YUV_BITS-1:0]  c2;
    logic                        vSwitch;
    logic [DAC_BITS-1:0]         dacSample;

    modport master (
        output palMode, lineStart, subcarrierPhase, sync, burst, blank, y, c1, c2,
        input  vSwitch, dacSample
    );

    modport slave (
        input  palMode, lineStart, subcarrierPhase, sync, burst, blank, y, c1, c2,
        output vSwitch, dacSample
    );
endinterface

// File: rtl/composite_video_encoder.sv
// -----------------------------------------------------------------------------
// composite_video_encoder
// NTSC/PAL composite video sample generator driving an R-2R DAC.
// An input capture register is followed by four pipeline stages, so inputs
// sampled at edge n reach dacSample after edge n+4:
//   stage 1 : flag priority (sync > burst > blank > active), burst injection,
//             cos/sin LUT lookup, V-switch sign
//   stage 2 : luma scaling, chroma modulation, DAC offset
//   stage 3 : composite sum
//   stage 4 : DAC code extraction
// Ports:
//   phaseClock : sample clock (16x subcarrier at defaults)
//   reset      : synchronous, active-high
//   bus        : composite_video_if.slave (inputs, vSwitch, dacSample)
// Build option:
//   COMPOSITE_SATURATE_EN : clamp stage-4 code to [0, 2^DAC_BITS-1];
//                           undefined -> plain bit-slice (wrapping).
// -----------------------------------------------------------------------------
module composite_video_encoder #(
    parameter int unsigned PHASE_BITS      = 4,
    parameter int unsigned DAC_BITS        = 5,
    parameter int unsigned YUV_BITS        = 9,
    parameter int unsigned COS_FRAC_BITS   = 7,
    parameter int unsigned DAC_LEVEL_SHIFT = 11,
    parameter int unsigned SYNC_LEVEL      = 0,
    parameter int unsigned BLANK_LEVEL     = 8,
    parameter int unsigned BLACK_LEVEL     = 10
) (
    input  logic               phaseClock,
    input  logic               reset,
    composite_video_if.slave   bus
);

    localparam int unsigned LUT_DEPTH = 1 << PHASE_BITS;
    localparam int unsigned QUARTER   = 1 << (PHASE_BITS - 2);
    localparam int unsigned COS_W     = COS_FRAC_BITS + 1;
    localparam int unsigned PROD_W    = YUV_BITS + COS_W;
    localparam int unsigned SUM_A     = YUV_BITS + COS_FRAC_BITS + 3;
    localparam int unsigned SUM_B     = DAC_BITS + DAC_LEVEL_SHIFT + 2;
    localparam int unsigned SUM_W     = (SUM_A > SUM_B) ? SUM_A : SUM_B;
    localparam int unsigned AMP       = (1 << COS_FRAC_BITS) - 1;

    // Stage 3 only keeps the bits stage 4 consumes.
`ifdef COMPOSITE_SATURATE_EN
    localparam int unsigned S3_W = SUM_W - DAC_LEVEL_SHIFT;
`else
    localparam int unsigned S3_W = DAC_BITS;
`endif

    // Elaboration-time round(AMP*cos(2*pi*k/LUT_DEPTH)) using a fixed-point
    // (2^30) Taylor series on the first quadrant.
    function automatic int cos_entry(input int k);
        longint one;
        longint pi_fx;
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint rnd;
        int     m;
        bit     neg;
        one   = 64'sd1 <<< 30;
        pi_fx = 64'sd3373259426;
        m     = k % int'(LUT_DEPTH);
        neg   = 1'b0;
        if (m > int'(LUT_DEPTH / 2)) begin
            m = int'(LUT_DEPTH) - m;
        end
        if (m > int'(LUT_DEPTH / 4)) begin
            m   = int'(LUT_DEPTH / 2) - m;
            neg = 1'b1;
        end
        x    = (2 * pi_fx * longint'(m)) / longint'(LUT_DEPTH);
        x2   = (x * x) >>> 30;
        term = one;
        acc  = one;
        for (int i = 1; i <= 9; i++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i)));
            acc  = acc + term;
        end
        rnd = (acc * longint'(AMP) + (one >>> 1)) >>> 30;
        return neg ? -int'(rnd) : int'(rnd);
    endfunction

    logic signed [COS_W-1:0] cos_lut [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam logic signed [COS_W-1:0] ENTRY = COS_W'(cos_entry(k));
        assign cos_lut[k] = ENTRY;
    end

    // V-switch
    logic vswitch_d, vswitch_q;

    // Input capture
    logic                       in_pal_d,   in_pal_q;
    logic                       in_vsw_d,   in_vsw_q;
    logic                       in_sync_d,  in_sync_q;
    logic                       in_burst_d, in_burst_q;
    logic                       in_blank_d, in_blank_q;
    logic [PHASE_BITS-1:0]      in_phase_d, in_phase_q;
    logic signed [YUV_BITS-1:0] in_y_d,     in_y_q;
    logic signed [YUV_BITS-1:0] in_c1_d,    in_c1_q;
    logic signed [YUV_BITS-1:0] in_c2_d,    in_c2_q;

    // Stage 1
    logic signed [YUV_BITS-1:0] s1_y_d,   s1_y_q;
    logic signed [YUV_BITS-1:0] s1_c1_d,  s1_c1_q;
    logic signed [YUV_BITS-1:0] s1_c2_d,  s1_c2_q;
    logic [DAC_BITS-1:0]        s1_off_d, s1_off_q;
    logic signed [COS_W-1:0]    s1_cos_d, s1_cos_q;
    logic signed [COS_W-1:0]    s1_sin_d, s1_sin_q;
    logic                       s1_neg_d, s1_neg_q;

    // Stage 2
    logic signed [SUM_W-1:0]    s2_yc_d,  s2_yc_q;
    logic signed [SUM_W-1:0]    s2_c1c_d, s2_c1c_q;
    logic signed [SUM_W-1:0]    s2_c2c_d, s2_c2c_q;
    logic signed [SUM_W-1:0]    s2_off_d, s2_off_q;

    // Stage 3 / 4
    logic [S3_W-1:0]            s3_sum_d, s3_sum_q;
    logic [DAC_BITS-1:0]        dac_d,    dac_q;

    logic [PHASE_BITS-1:0]      sin_idx;
    logic signed [PROD_W-1:0]   c1_prod;
    logic signed [PROD_W-1:0]   c2_prod;

    // Next-state logic for every pipeline register
    always_comb begin
        // V-switch: toggles per PAL line, held at 0 in NTSC
        vswitch_d  = bus.palMode ? (vswitch_q ^ bus.lineStart) : 1'b0;

        // Input capture; the V-switch sign travels with the sample
        in_pal_d   = bus.palMode;
        in_vsw_d   = vswitch_q;
        in_sync_d  = bus.sync;
        in_burst_d = bus.burst;
        in_blank_d = bus.blank;
        in_phase_d = bus.subcarrierPhase;
        in_y_d     = bus.y;
        in_c1_d    = bus.c1;
        in_c2_d    = bus.c2;

        // Stage 1: flag priority and burst injection
        s1_y_d   = '0;
        s1_c1_d  = '0;
        s1_c2_d  = '0;
        s1_off_d = DAC_BITS'(BLANK_LEVEL);
        if (in_sync_q) begin
            s1_off_d = DAC_BITS'(SYNC_LEVEL);
        end else if (in_burst_q) begin
            if (in_pal_q) begin
                // 135 deg; stage 2 swings it to -135 deg on V-switched lines
                s1_c1_d = YUV_BITS'(-45);
                s1_c2_d = YUV_BITS'(45);
            end else begin
                // amplitude 64 at -57 deg
                s1_c1_d = YUV_BITS'(35);
                s1_c2_d = YUV_BITS'(-54);
            end
        end else if (!in_blank_q) begin
            s1_off_d = DAC_BITS'(BLACK_LEVEL);
            s1_y_d   = in_y_q;
            s1_c1_d  = in_c1_q;
            s1_c2_d  = in_c2_q;
        end
        sin_idx  = in_phase_q - PHASE_BITS'(QUARTER);
        s1_cos_d = cos_lut[in_phase_q];
        s1_sin_d = cos_lut[sin_idx];
        s1_neg_d = in_pal_q & in_vsw_q;

        // Stage 2: scale luma, modulate chroma, offset (level + 0.5)
        c1_prod  = PROD_W'(s1_c1_q) * PROD_W'(s1_cos_q);
        c2_prod  = PROD_W'(s1_c2_q) * PROD_W'(s1_sin_q);
        s2_yc_d  = SUM_W'(s1_y_q) <<< COS_FRAC_BITS;
        s2_c1c_d = SUM_W'(c1_prod);
        s2_c2c_d = s1_neg_q ? -SUM_W'(c2_prod) : SUM_W'(c2_prod);
        s2_off_d = SUM_W'({s1_off_q, 1'b1}) <<< (DAC_LEVEL_SHIFT - 1);

        // Stage 3: composite sum, pre-shifted to DAC scale
        s3_sum_d = S3_W'((s2_yc_q + s2_c1c_q + s2_c2c_q + s2_off_q) >>> DAC_LEVEL_SHIFT);

        // Stage 4: DAC code
`ifdef COMPOSITE_SATURATE_EN
        if (s3_sum_q[S3_W-1]) begin
            dac_d = '0;
        end else if (|s3_sum_q[S3_W-2:DAC_BITS]) begin
            dac_d = '1;
        end else begin
            dac_d = s3_sum_q[DAC_BITS-1:0];
        end
`else
        dac_d = s3_sum_q;
`endif
    end

    // Pipeline registers; reset fills every stage with a blank sample
    always_ff @(posedge phaseClock) begin
        if (reset) begin
            vswitch_q  <= 1'b0;
            in_pal_q   <= 1'b0;
            in_vsw_q   <= 1'b0;
            in_sync_q  <= 1'b0;
            in_burst_q <= 1'b0;
            in_blank_q <= 1'b1;
            in_phase_q <= '0;
            in_y_q     <= '0;
            in_c1_q    <= '0;
            in_c2_q    <= '0;
            s1_y_q     <= '0;
            s1_c1_q    <= '0;
            s1_c2_q    <= '0;
            s1_off_q   <= DAC_BITS'(BLANK_LEVEL);
            s1_cos_q   <= '0;
            s1_sin_q   <= '0;
            s1_neg_q   <= 1'b0;
            s2_yc_q    <= '0;
            s2_c1c_q   <= '0;
            s2_c2c_q   <= '0;
            s2_off_q   <= SUM_W'({DAC_BITS'(BLANK_LEVEL), 1'b1}) <<< (DAC_LEVEL_SHIFT - 1);
            s3_sum_q   <= S3_W'(BLANK_LEVEL);
            dac_q      <= DAC_BITS'(BLANK_LEVEL);
        end else begin
            vswitch_q  <= vswitch_d;
            in_pal_q   <= in_pal_d;
            in_vsw_q   <= in_vsw_d;
            in_sync_q  <= in_sync_d;
            in_burst_q <= in_burst_d;
            in_blank_q <= in_blank_d;
            in_phase_q <= in_phase_d;
            in_y_q     <= in_y_d;
            in_c1_q    <= in_c1_d;
            in_c2_q    <= in_c2_d;
            s1_y_q     <= s1_y_d;
            s1_c1_q    <= s1_c1_d;
            s1_c2_q    <= s1_c2_d;
            s1_off_q   <= s1_off_d;
            s1_cos_q   <= s1_cos_d;
            s1_sin_q   <= s1_sin_d;
            s1_neg_q   <= s1_neg_d;
            s2_yc_q    <= s2_yc_d;
            s2_c1c_q   <= s2_c1c_d;
            s2_c2c_q   <= s2_c2c_d;
            s2_off_q   <= s2_off_d;
            s3_sum_q   <= s3_sum_d;
            dac_q      <= dac_d;
        end
    end

    assign bus.vSwitch   = vswitch_q;
    assign bus.dacSample = dac_q;

endmodule
